layer2_mac_unit: RTL and testbench
==================================

# layer2_mac_unit

Downstream consumer of the layer-2 load controller: once a 4x4 picture window sits in the window buffer, this block reads the 16 buffer entries and the matching weights of the 4 filters, accumulates 4 dot products, applies ReLU/shift/saturation, and writes one 4-channel result to the output map. It then requests the next window over the `ldBuf`/`ldDone` handshake. After 100 windows (10x10 output map from a 13x13 picture), it raises `layerDone`.

## Interface
Parameters:
- `DATA_W`, 8, signed width of pixels, weights and output channels
- `ACC_W`, 2*DATA_W+4, signed accumulator width; holds 16 full-precision products without overflow
- `SHIFT`, 4, arithmetic right shift applied before saturation
- `N_WIN`, 100, windows per layer

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  asynchronous, active-low reset
- `ldDone`  in  1  level; window buffer and filter registers are valid
- `rdI`, `rdJ`  out  2 each  window row/column read index to buffer and filters
- `bufData`  in  DATA_W  signed pixel at (`rdI`,`rdJ`), combinational read
- `filData`  in  4*DATA_W  signed weights of filters 3..0 at (`rdI`,`rdJ`); filter k in bits [k*DATA_W +: DATA_W]
- `ldBuf`  out  1  one-cycle request for the next window
- `outWrEn`  out  1  output-map write strobe
- `outAddr`  out  7  output index = window row*10 + window column
- `outData`  out  4*DATA_W  4 result channels, same packing as `filData`
- `layerDone`  out  1  all `N_WIN` results written

## Operation
- States: IDLE, MAC, WRITE, REQ, SYNC, FIN.
- IDLE: if `ldDone`=1, go to MAC and clear all 4 accumulators and the 4-bit element counter.
- MAC: the element counter drives `rdI` = cnt[3:2] and `rdJ` = cnt[1:0]. Every cycle, acc[k] += bufData*filData[k] (signed, sign-extended to ACC_W). After cnt=15, go to WRITE.
- WRITE: `outWrEn`=1 and `outAddr` = window counter. outData[k] = sat(relu(acc[k]) >>> SHIFT). Go to REQ.
- REQ: `ldBuf`=1 for exactly one cycle.
  - If window counter = N_WIN-1, go to FIN.
  - Otherwise increment the window counter and go to SYNC.
- SYNC: wait until `ldDone`=0, then go to IDLE. This prevents reuse of a stale window.
- FIN: `layerDone`=1 and all other outputs are idle. The block stays in FIN until reset. `ldDone` is ignored here, including the loader holding `ldDone` high after its last window.
- Saturation (with ReLU): clamp to [0, 2^(DATA_W-1)-1], i.e. 127 for DATA_W=8.
- Outputs outside their state:
  - `ldBuf` and `outWrEn` are 0.
  - `outData` is 0.
  - `rdI` and `rdJ` are 0.

## Timing
- Reset (`rst`=0, asynchronous) forces:
  - state to IDLE;
  - all counters and accumulators to 0;
  - `ldBuf`, `outWrEn`, `layerDone` to 0;
  - `outAddr`, `outData`, `rdI`, `rdJ` to 0.
- Reset mid-MAC or mid-WRITE discards the partial window; no write is issued.
- Cycle timing, taking `ldDone` sampled high in IDLE at cycle t:
  - MAC occupies t+1..t+16;
  - WRITE is t+17;
  - REQ is t+18;
  - SYNC is t+19 or later.
- Window period is 20 cycles plus the loader's reload time.
- The `ldBuf` pulse is Moore-decoded from REQ, so the loader samples it on the edge that ends REQ.
- If `ldDone` is already 0 in the first SYNC cycle, SYNC lasts exactly one cycle.
- If `ldDone` drops during MAC, this is a loader protocol error. Accumulation continues and no recovery is defined.
- Accumulators never wrap: 16·(2^(DATA_W-1))^2 < 2^(ACC_W-1).

## Configuration
- `L2_RELU_EN` defined: negative accumulators produce 0, then shift and clamp to [0,127] (DATA_W=8).
- `L2_RELU_EN` undefined: no ReLU. Arithmetic shift, then signed clamp to [-128,127].

## Test plan
- Reset check: hold `rst`=0 with random inputs. All outputs are 0 and state is IDLE. Release reset and keep `ldDone`=0 for 10 cycles: no `ldBuf` and no write.
- Single window: pixels all 1, filter k weights all k+1, `SHIFT`=0, `ldDone` raised at cycle 5.
  - Exactly 16 MAC cycles with `rdI`/`rdJ` stepping 0,0 → 3,3.
  - Write at cycle 22 with `outAddr`=0 and outData = {64,48,32,16}.
  - `ldBuf` high only at cycle 23.
- Saturation and sign: pixels 127, weights 127 for filter 0 and -128 for filter 1, `SHIFT`=4.
  - Filter 0 gives 127.
  - Filter 1 gives 0 with `L2_RELU_EN`, and -128 without it.
- Handshake: hold `ldDone` high for 3 cycles after `ldBuf`. Block stays in SYNC for 3 cycles, then re-enters IDLE. No double write, and `outAddr` advances by exactly 1.
- Full layer: loader model serves 100 windows with a random 0-7 cycle reload delay.
  - 100 writes with `outAddr` 0..99 in order.
  - Exactly 99 `ldBuf` pulses during REQ→SYNC transitions, plus one in the final REQ.
  - `layerDone` rises after the last write and stays high while `ldDone` remains 1.
- Reset mid-MAC: pull `rst` low at element 7 of window 42. Outputs clear at once with no write. After release, the next window writes `outAddr`=0.

Source files
------------

// File: rtl/layer2_mac_unit.sv
// layer2_mac_unit: reads a 4x4 window plus 4 filters, accumulates 4 dot products and writes one
// 4-channel result per window. Define L2_RELU_EN to clamp negative accumulators to zero.
module layer2_mac_unit #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2*DATA_W+4,
  parameter int SHIFT  = 4,
  parameter int N_WIN  = 100
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ldDone,
  output logic [1:0]                 rdI,
  output logic [1:0]                 rdJ,
  input  logic signed [DATA_W-1:0]   bufData,
  input  logic [4*DATA_W-1:0]        filData,
  output logic                       ldBuf,
  output logic                       outWrEn,
  output logic [6:0]                 outAddr,
  output logic [4*DATA_W-1:0]        outData,
  output logic                       layerDone
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MAC   = 3'd1,
    WRITE = 3'd2,
    REQ   = 3'd3,
    SYNC  = 3'd4,
    FIN   = 3'd5
  } state_t;

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2**(DATA_W-1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  state_t                        state_r, state_s;
  logic [3:0]                    cnt_r;
  logic [6:0]                    win_r;
  logic signed [ACC_W-1:0]       acc_r [4];
  logic signed [ACC_W-1:0]       acc_s [4];
  logic signed [DATA_W-1:0]      w_s [4];
  logic signed [2*DATA_W-1:0]    prod_s [4];
  logic [4*DATA_W-1:0]           wr_data_s;
  logic                          ld_buf_r, out_wr_en_r, layer_done_r;
  logic [4*DATA_W-1:0]           out_data_r;

  function automatic logic [DATA_W-1:0] sat_fn(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] v;
`ifdef L2_RELU_EN
    v = a[ACC_W-1] ? {ACC_W{1'b0}} : a;
`else
    v = a;
`endif
    v = v >>> SHIFT;
    if (v > SAT_HI) begin
      return SAT_HI[DATA_W-1:0];
    end else if (v < SAT_LO) begin
      return SAT_LO[DATA_W-1:0];
    end else begin
      return v[DATA_W-1:0];
    end
  endfunction

  // Per-filter products of the current pixel and weight.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_s[k]    = filData[k*DATA_W +: DATA_W];
      prod_s[k] = bufData * w_s[k];
    end
  end

  // Next-state, accumulator update and result formatting.
  always_comb begin
    state_s   = state_r;
    wr_data_s = {(4*DATA_W){1'b0}};
    for (int k = 0; k < 4; k++) begin
      acc_s[k] = acc_r[k];
    end
    case (state_r)
      IDLE: begin
        if (ldDone) begin
          state_s = MAC;
          for (int k = 0; k < 4; k++) begin
            acc_s[k] = {ACC_W{1'b0}};
          end
        end else begin
          state_s = IDLE;
        end
      end
      MAC: begin
        for (int k = 0; k < 4; k++) begin
          acc_s[k] = acc_r[k] + {{(ACC_W-2*DATA_W){prod_s[k][2*DATA_W-1]}}, prod_s[k]};
        end
        if (cnt_r == 4'd15) begin
          state_s = WRITE;
        end else begin
          state_s = MAC;
        end
      end
      WRITE: state_s = REQ;
      REQ: begin
        if (win_r == 7'(N_WIN-1)) begin
          state_s = FIN;
        end else begin
          state_s = SYNC;
        end
      end
      // Hold off until the loader has withdrawn the window just consumed.
      SYNC: begin
        if (!ldDone) begin
          state_s = IDLE;
        end else begin
          state_s = SYNC;
        end
      end
      FIN:     state_s = FIN;
      default: state_s = IDLE;
    endcase
    for (int k = 0; k < 4; k++) begin
      wr_data_s[k*DATA_W +: DATA_W] = sat_fn(acc_s[k]);
    end
  end

  // State, element/window counters and accumulators.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      win_r   <= 7'd0;
      for (int k = 0; k < 4; k++) begin
        acc_r[k] <= {ACC_W{1'b0}};
      end
    end else begin
      state_r <= state_s;
      cnt_r   <= (state_r == MAC) ? cnt_r + 4'd1 : 4'd0;
      if (state_r == REQ && state_s == SYNC) begin
        win_r <= win_r + 7'd1;
      end else begin
        win_r <= win_r;
      end
      for (int k = 0; k < 4; k++) begin
        acc_r[k] <= acc_s[k];
      end
    end
  end

  // Registered, state-decoded strobes and write data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_buf_r     <= 1'b0;
      out_wr_en_r  <= 1'b0;
      layer_done_r <= 1'b0;
      out_data_r   <= {(4*DATA_W){1'b0}};
    end else begin
      ld_buf_r     <= (state_s == REQ);
      out_wr_en_r  <= (state_s == WRITE);
      layer_done_r <= (state_s == FIN);
      out_data_r   <= (state_s == WRITE) ? wr_data_s : {(4*DATA_W){1'b0}};
    end
  end

  assign rdI       = cnt_r[3:2];
  assign rdJ       = cnt_r[1:0];
  assign outAddr   = win_r;
  assign ldBuf     = ld_buf_r;
  assign outWrEn   = out_wr_en_r;
  assign outData   = out_data_r;
  assign layerDone = layer_done_r;

endmodule

// File: tb/tb_layer2_mac_unit.sv
// Directed bench for layer2_mac_unit: acts as the window loader and checks every written
// result against a dot-product model of the window it served.
module tb_layer2_mac_unit;
  localparam int NW = 100;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ldDone = 1'b0;
  logic [1:0]        rdI, rdJ;
  logic signed [7:0] bufData;
  logic [31:0]       filData;
  logic              ldBuf, outWrEn, layerDone;
  logic [6:0]        outAddr;
  logic [31:0]       outData;

  logic signed [7:0] pix [16];
  logic signed [7:0] wt [4][16];
  logic [3:0]        idx;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_mem [128];
  int          exp_cnt = 0;
  int          n_wr = 0;
  int          n_ldbuf = 0;
  logic        prev_wr = 1'b0;
  logic        fin_flag = 1'b0;
  logic [31:0] last_wr_data = 32'd0;
  logic [6:0]  last_wr_addr = 7'd0;

  assign idx     = {rdI, rdJ};
  assign bufData = pix[idx];
  assign filData = {wt[3][idx], wt[2][idx], wt[1][idx], wt[0][idx]};

  always #5 clk = ~clk;

  layer2_mac_unit dut (
    .clk(clk), .rst(rst), .ldDone(ldDone), .rdI(rdI), .rdJ(rdJ),
    .bufData(bufData), .filData(filData), .ldBuf(ldBuf), .outWrEn(outWrEn),
    .outAddr(outAddr), .outData(outData), .layerDone(layerDone)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Each channel: sum of 16 products, optional ReLU, arithmetic shift by 4, clamp to 8 bits.
  function automatic logic [31:0] model();
    logic [31:0] r;
    int s;
    r = 32'd0;
    for (int k = 0; k < 4; k++) begin
      s = 0;
      for (int e = 0; e < 16; e++) s += int'(pix[e]) * int'(wt[k][e]);
`ifdef L2_RELU_EN
      if (s < 0) s = 0;
`endif
      s = s >>> 4;
      if (s > 127) s = 127;
      else if (s < -128) s = -128;
      r[k*8 +: 8] = s[7:0];
    end
    return r;
  endfunction

  task automatic fill_const(input logic signed [7:0] p, input logic signed [7:0] w0,
                            input logic signed [7:0] w1, input logic signed [7:0] w2,
                            input logic signed [7:0] w3);
    for (int e = 0; e < 16; e++) begin
      pix[e] = p; wt[0][e] = w0; wt[1][e] = w1; wt[2][e] = w2; wt[3][e] = w3;
    end
  endtask

  task automatic fill_random();
    for (int e = 0; e < 16; e++) begin
      pix[e] = 8'($urandom);
      for (int k = 0; k < 4; k++) wt[k][e] = 8'($urandom);
    end
  endtask

  task automatic push_expected();
    exp_mem[exp_cnt] = model();
    exp_cnt++;
  endtask

  // Present the current window after d cycles, wait for the request, hold ldDone h more cycles.
  task automatic serve(input int d, input int h);
    logic found;
    found = 1'b0;
    repeat (d) @(posedge clk);
    #1 ldDone = 1'b1;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (ldBuf) found = 1'b1;
    end
    check("ldbuf_seen", 64'(found), 64'd1);
    @(posedge clk); #1;
    repeat (h) @(posedge clk);
    #1 ldDone = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] sat_lit;
    logic        found;
    int          e;

    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          check("reset_outputs", {18'd0, ldBuf, outWrEn, layerDone, outAddr, outData, rdI, rdJ}, 64'd0);
          n_wr = 0; n_ldbuf = 0; prev_wr = 1'b0; fin_flag = 1'b0;
        end else begin
          if (outWrEn) begin
            checks++;
            if (n_wr >= exp_cnt) begin
              errors++;
              $display("FAIL unexpected_write: addr %0d data %0h with %0d windows served", outAddr, outData, exp_cnt);
            end else begin
              checks--;
              check("write_addr_data", {25'd0, outAddr, outData}, {25'd0, n_wr[6:0], exp_mem[n_wr]});
            end
            last_wr_data = outData;
            last_wr_addr = outAddr;
            n_wr++;
          end else begin
            check("idle_outdata", 64'(outData), 64'd0);
          end
          check("ldbuf_after_write", 64'(ldBuf), 64'(prev_wr));
          check("layer_done", 64'(layerDone), 64'(fin_flag));
          if (ldBuf) n_ldbuf++;
          if (ldBuf && n_wr == NW) fin_flag = 1'b1;
          prev_wr = outWrEn;
        end
      end
    join_none

    // Reset with random inputs, then quiet idle.
    #1 rst = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      ldDone = 1'($urandom);
      fill_random();
    end
    ldDone = 1'b0;
    @(negedge clk); #2 rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("idle_quiet", 64'(n_wr + n_ldbuf), 64'd0);

    // Single window: pixels 1, filter k weights k+1; sums 16,32,48,64 shifted by 4.
    fill_const(8'sd1, 8'sd1, 8'sd2, 8'sd3, 8'sd4);
    push_expected();
    check("model_pin_single", 64'(exp_mem[0]), 64'h04030201);
    ldDone = 1'b1;
    for (int n = 1; n <= 22; n++) begin
      @(negedge clk);
      e = (n >= 2 && n <= 17) ? n - 2 : 0;
      check("rd_index", 64'({rdI, rdJ}), 64'(e));
      check("write_cycle", 64'(outWrEn), 64'(n == 18));
      check("ldbuf_cycle", 64'(ldBuf), 64'(n == 19));
      if (n == 18) check("single_data", {25'd0, outAddr, outData}, 64'h04030201);
    end
    @(posedge clk); #1 ldDone = 1'b0;
    @(posedge clk); #1;

    // Saturation and sign handling.
    fill_const(8'sd127, 8'sd127, -8'sd128, 8'sd0, 8'sd0);
    wt[2][5]  = -8'sd1;
    wt[3][10] = 8'sd1;
`ifdef L2_RELU_EN
    sat_lit = 32'h0700007F;
`else
    sat_lit = 32'h07F8807F;
`endif
    push_expected();
    check("model_pin_sat", 64'(exp_mem[1]), 64'(sat_lit));
    serve(2, 0);
    check("sat_data", 64'(last_wr_data), 64'(sat_lit));

    // Loader holds ldDone for 3 extra cycles after the request.
    fill_random();
    push_expected();
    serve(1, 3);
    check("handshake_count", 64'(n_wr), 64'd3);
    check("handshake_addr", 64'(last_wr_addr), 64'd2);

    // Remainder of the layer with random reload delay; the last window keeps ldDone high.
    for (int w = 3; w < NW; w++) begin
      fill_random();
      push_expected();
      serve($urandom_range(0, 7), (w == NW-1) ? 10 : 0);
    end
    #1 ldDone = 1'b1;
    repeat (5) @(posedge clk);
    #1 ldDone = 1'b0;
    check("layer_writes", 64'(n_wr), 64'd100);
    check("layer_ldbufs", 64'(n_ldbuf), 64'd100);
    check("layer_done_final", 64'(layerDone), 64'd1);

    // Reset in the middle of window 42.
    @(negedge clk); #2 rst = 1'b0;
    exp_cnt = 0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    for (int w = 0; w < 42; w++) begin
      fill_random();
      push_expected();
      serve(0, 0);
    end
    fill_random();
    push_expected();
    ldDone = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (rdI == 2'd1 && rdJ == 2'd3) found = 1'b1;
    end
    check("mid_mac_reached", 64'(found), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_mac_reset_outs", {18'd0, ldBuf, outWrEn, layerDone, outAddr, outData, rdI, rdJ}, 64'd0);
    exp_cnt = 0;
    ldDone = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    fill_random();
    push_expected();
    serve(3, 0);
    check("post_reset_addr", 64'(last_wr_addr), 64'd0);
    check("post_reset_count", 64'(n_wr), 64'd1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
